// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU status for the program loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 5
) ();

  // Load control
  logic              start;
  logic [5:0]        num_words;

  // Upstream byte stream
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;

  // Instruction-memory write port
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_we;

  // CPU status
  logic              cpu_hold;
  logic              done;

  // Drives the stream and control, observes the loader
  modport master (
    output start,
    output num_words,
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_addr,
    input  mem_data,
    input  mem_we,
    input  cpu_hold,
    input  done
  );

  // The loader itself
  modport slave (
    input  start,
    input  num_words,
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_addr,
    output mem_data,
    output mem_we,
    output cpu_hold,
    output done
  );

endinterface

// File: rtl/program_loader.sv
// Program loader: assembles a big-endian byte stream into 32-bit words and writes them to
// instruction memory, holding the CPU until the requested number of words has landed.
module program_loader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  program_loader_if.slave    bus
);

  // Word counts need one more bit than the address so a full-depth load does not wrap to 0
  localparam int unsigned      CntW     = ADDR_W + 1;
  localparam logic [CntW-1:0]  MaxCount = CntW'(MEM_WORDS);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;

  logic [CntW-1:0]   eff_count;
  logic              start_ok;
  logic              xfer;
  logic              last_byte;
  logic              last_word;

  // Clamp the requested word count to the memory depth
  always_comb begin
    if (32'(bus.num_words) > MEM_WORDS) begin
      eff_count = MaxCount;
    end else begin
      eff_count = CntW'(bus.num_words);
    end
  end

  // Handshake and position decode shared by the FSM and the datapath
  always_comb begin
    start_ok  = bus.start && ((state_q == StIdle) || (state_q == StDone));
    xfer      = (state_q == StRecv) && bus.byte_valid;
    last_byte = (byte_idx_q == 2'd3);
    last_word = (word_idx_q == (count_q - CntOne));
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = (eff_count == '0) ? StDone : StRecv;
        end
      end
      StRecv: begin
        if (bus.byte_valid && last_byte) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        state_d = last_word ? StDone : StRecv;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: all decoded straight from state so reset forces them immediately
  always_comb begin
    bus.byte_ready = (state_q == StRecv);
    bus.mem_we     = (state_q == StWrite);
    bus.done       = (state_q == StDone);
    bus.cpu_hold   = (state_q != StDone);
  end

  // Datapath next state: counters, byte packing and the held write address/data
  always_comb begin
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    data_d     = data_q;

    if (start_ok) begin
      count_d    = eff_count;
      word_idx_d = '0;
      byte_idx_d = '0;
    end

    if (xfer) begin
      byte_idx_d = byte_idx_q + 2'd1;
      shift_d    = {shift_q[15:0], bus.byte_data};
      // Capture the finished word here so it is presented during the following write cycle
      if (last_byte) begin
        data_d = {shift_q, bus.byte_data};
        addr_d = word_idx_q[ADDR_W-1:0];
      end
    end

    if ((state_q == StWrite) && !last_word) begin
      word_idx_d = word_idx_q + CntOne;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;

`ifndef SYNTHESIS
  // Each word is written exactly once
  a_we_single : assert property (@(posedge clock) disable iff (!reset_n)
    bus.mem_we |=> !bus.mem_we);

  // Bytes are never accepted while a word is being written
  a_no_ready_in_write : assert property (@(posedge clock) disable iff (!reset_n)
    !(bus.byte_ready && bus.mem_we));

  // The CPU is released only once the load is complete
  a_done_releases : assert property (@(posedge clock) disable iff (!reset_n)
    bus.done |-> !bus.cpu_hold);

  // The word index stays inside the latched count during a load
  a_idx_in_range : assert property (@(posedge clock) disable iff (!reset_n)
    ((state_q == StRecv) || (state_q == StWrite)) |-> (word_idx_q < count_q));
`endif

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned MEM_WORDS = 32;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t        exp_q[$];
  logic [7:0]  prog[$];
  logic [31:0] last_data;
  logic [31:0] last_addr;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(
    .ADDR_W   (ADDR_W),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clock  (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!reset_n) begin
      last_data <= '0;
      last_addr <= '0;
    end else if (bus.mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got write addr %0d data %0h expected no write",
                 bus.mem_addr, bus.mem_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("wr_data", bus.mem_data, e.data);
        check("wr_latency", 32'(cyc), 32'(e.cyc));
        check("ready_in_write", 32'(bus.byte_ready), 32'd0);
      end
      last_data <= bus.mem_data;
      last_addr <= 32'(bus.mem_addr);
    end else begin
      check("hold_data", bus.mem_data, last_data);
      check("hold_addr", 32'(bus.mem_addr), last_addr);
    end
  end

  task automatic fill_random(input int n);
    int eff;
    eff = (n > int'(MEM_WORDS)) ? int'(MEM_WORDS) : n;
    prog.delete();
    for (int i = 0; i < eff * 4; i++) prog.push_back(8'($urandom));
  endtask

  // Caller is at posedge+1; leaves at posedge+1 after the edge that sampled start
  task automatic pulse_start(input int n);
    bus.start     = 1'b1;
    bus.num_words = 6'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Reference model: words are prog[4i..4i+3] big-endian at address i, written one cycle
  // after the 4th byte is accepted. pct<0 toggles valid every cycle.
  task automatic run_load(input int n, input int pct, input int glitch_at, input int stop_at);
    int eff;
    int idx;
    int budget;
    bit acc;
    eff = (n > int'(MEM_WORDS)) ? int'(MEM_WORDS) : n;
    pulse_start(n);
    if (eff == 0) begin
      @(negedge clk);
      check("zero_done", 32'(bus.done), 32'd1);
      check("zero_hold", 32'(bus.cpu_hold), 32'd0);
      @(posedge clk);
      #1;
      return;
    end
    idx    = 0;
    budget = 0;
    while (idx < eff * 4 && idx != stop_at && budget < 4000) begin
      if (pct < 0) bus.byte_valid = (budget % 2 == 0);
      else         bus.byte_valid = (int'($urandom_range(99)) < pct);
      bus.byte_data = prog[idx];
      if (idx == glitch_at) begin
        bus.start     = 1'b1;
        bus.num_words = 6'd3;
      end
      @(negedge clk);
      if (budget == 0) begin
        check("load_hold", 32'(bus.cpu_hold), 32'd1);
        check("load_not_done", 32'(bus.done), 32'd0);
      end
      acc = bus.byte_valid && bus.byte_ready;
      if (acc && (idx % 4 == 3)) begin
        exp_q.push_back('{addr: idx / 4,
                          data: {prog[idx-3], prog[idx-2], prog[idx-1], prog[idx]},
                          cyc:  cyc + 1});
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (acc) idx++;
      budget++;
    end
    bus.byte_valid = 1'b0;
    if (budget >= 4000) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got %0d bytes accepted expected %0d", idx, eff * 4);
      return;
    end
    if (idx == stop_at) return;
    @(negedge clk);
    check("done_in_write", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("done", 32'(bus.done), 32'd1);
    check("done_hold", 32'(bus.cpu_hold), 32'd0);
    check("done_ready", 32'(bus.byte_ready), 32'd0);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_data"}, bus.mem_data, 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'd1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    bus.start      = 1'b0;
    bus.num_words  = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    reset_n        = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_noclk");
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst_clk");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(bus.byte_ready), 32'd0);
    check("idle_hold", 32'(bus.cpu_hold), 32'd1);

    // Single word with known bytes
    prog.delete();
    prog.push_back(8'h8C);
    prog.push_back(8'h01);
    prog.push_back(8'h00);
    prog.push_back(8'h04);
    run_load(1, 100, -1, -1);

    // Full depth, valid held high (also a restart from DONE)
    fill_random(32);
    run_load(32, 100, -1, -1);

    // Valid toggling 1,0,1,0
    fill_random(3);
    run_load(3, -1, -1, -1);

    // Random counts and valid densities
    for (int k = 0; k < 4; k++) begin
      int n;
      n = int'($urandom_range(1, 8));
      fill_random(n);
      run_load(n, int'($urandom_range(30, 100)), -1, -1);
    end

    // Zero words, then a saturating count
    run_load(0, 100, -1, -1);
    fill_random(40);
    run_load(40, 100, -1, -1);

    // Start pulse during RECV must be ignored
    fill_random(4);
    run_load(4, 70, 5, -1);

    // Reset after 2 bytes of word 3
    fill_random(5);
    run_load(5, 100, -1, 14);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    check("rst_mid_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    fill_random(2);
    run_load(2, 100, -1, -1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: ADDR_W, default 5, instruction-memory address width.
REQ-002 Parameter: MEM_WORDS, default 32, instruction-memory depth in 32-bit words.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed below.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle pulse that begins a load; sampled only in IDLE and DONE.
REQ-007 num_words  input  6  number of words to load; 0 means none; values above MEM_WORDS saturate to MEM_WORDS.
REQ-008 byte_valid  input  1  upstream byte available.
REQ-009 byte_data  input  8  upstream byte.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 mem_addr  output  ADDR_W  instruction-memory write address.
REQ-012 mem_data  output  32  instruction word to write.
REQ-013 mem_we  output  1  write strobe, one cycle per word.
REQ-014 cpu_hold  output  1  holds the datapath (PC write disabled) while the program is not loaded.
REQ-015 done  output  1  load complete, level.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RECV, WRITE and DONE.
REQ-017 IDLE SHALL go to RECV on start when the effective count is at least 1, and SHALL go directly to DONE on start when num_words = 0.
REQ-018 On the start edge, the block SHALL latch the effective count, clear the word index to 0 and clear the byte index to 0.
REQ-019 In RECV, byte_ready SHALL be 1; a byte transfers on any cycle with byte_valid = 1 and byte_ready = 1.
REQ-020 Transferred bytes SHALL be packed big-endian: byte 0 to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
REQ-021 The byte index SHALL increment modulo 4 on each transfer; the 4th transfer SHALL move the FSM to WRITE.
REQ-022 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr = word index and mem_data = the assembled word.
REQ-023 The word is written in the cycle immediately after the 4th byte is accepted, so latency is 1 cycle.
REQ-024 In WRITE, byte_ready SHALL be 0; byte_valid held high SHALL NOT be consumed.
REQ-025 After WRITE, if word index = count-1 the FSM SHALL go to DONE; otherwise the word index SHALL increment and the FSM SHALL return to RECV.
REQ-026 Word index arithmetic SHALL use ADDR_W+1 bits so that count = 32 does not alias to 0; mem_addr SHALL be the low ADDR_W bits.
REQ-027 In DONE, done SHALL be 1, cpu_hold SHALL be 0 and byte_ready SHALL be 0.
REQ-028 A start in DONE SHALL re-enter the load (same rules as REQ-017/018) and deassert done and reassert cpu_hold on the next cycle.
REQ-029 A start in RECV or WRITE SHALL be ignored; the load in progress SHALL continue unaffected.
REQ-030 When mem_we is 0, mem_data and mem_addr SHALL hold their last values; they carry no meaning while mem_we is low.
REQ-031 cpu_hold SHALL be 1 in IDLE, RECV and WRITE.

Reset
REQ-032 While reset_n = 0, regardless of clock, the block SHALL force: state = IDLE, byte_ready = 0, mem_we = 0, mem_addr = 0, mem_data = 0, done = 0, cpu_hold = 1, and both indices = 0.
REQ-033 A reset mid-load SHALL discard any partial word; memory writes already issued are not undone.
REQ-034 After reset release, the block SHALL wait in IDLE for start.

Verification
REQ-035 Single word: num_words=1, start, then bytes 8C,01,00,04 -> one cycle later mem_we=1, mem_addr=0, mem_data=8C010004; the next cycle done=1, cpu_hold=0.
REQ-036 Full depth: num_words=32, 128 bytes with byte_valid held high -> 32 mem_we pulses at addresses 0..31, each 4 accept cycles plus 1 write cycle apart; done after the 32nd write; no write to address 0 after 31.
REQ-037 Backpressure and gaps: byte_valid toggling 1,0,1,0 -> only cycles with valid and ready high transfer; no byte is consumed during WRITE; assembled words are correct.
REQ-038 Edge counts: num_words=0 -> DONE next cycle with no mem_we; num_words=40 -> exactly 32 writes.
REQ-039 Reset mid-word: assert reset_n=0 after 2 bytes of word 3 -> outputs reach reset values immediately; a restarted load writes word 0 at address 0 with fresh bytes.
REQ-040 Restart: a start during RECV is ignored; a start in DONE -> done=0 and cpu_hold=1 the next cycle, and the reload overwrites from address 0.
